// File: rtl/vga_axil_regs_if.sv
// Shared AXI4-lite types and the host-bus interface of the VGA register file.
// Signal names are from the slave's point of view (_i driven by master).
package vga_axil_pkg;
  typedef logic [31:0] axil_addr_t;
  typedef logic [31:0] axil_data_t;
  localparam int STRB_W = $bits(axil_data_t) / 8;
  typedef logic [STRB_W-1:0] axil_strb_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

interface vga_axil_if;
  import vga_axil_pkg::*;

  axil_addr_t araddr_i;
  logic       arvalid_i;
  logic       arready_o;
  axil_data_t rdata_o;
  logic [1:0] rresp_o;
  logic       rvalid_o;
  logic       rready_i;
  axil_addr_t awaddr_i;
  logic       awvalid_i;
  logic       awready_o;
  axil_data_t wdata_i;
  axil_strb_t wstrb_i;
  logic       wvalid_i;
  logic       wready_o;
  logic [1:0] bresp_o;
  logic       bvalid_o;
  logic       bready_i;

  modport master (
    output araddr_i, arvalid_i, rready_i,
    output awaddr_i, awvalid_i,
    output wdata_i, wstrb_i, wvalid_i,
    output bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o,
    input  awready_o, wready_o,
    input  bresp_o, bvalid_o
  );

  modport slave (
    input  araddr_i, arvalid_i, rready_i,
    input  awaddr_i, awvalid_i,
    input  wdata_i, wstrb_i, wvalid_i,
    input  bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o,
    output awready_o, wready_o,
    output bresp_o, bvalid_o
  );
endinterface

// File: rtl/vga_axil_regs.sv
// AXI4-lite register file for the VGA core: CTRL, BG_COLOR, FRAME_CNT, ID.
// Define VGA_AXIL_REGS_IRQ_EN to add CTRL[2] irq_en, IRQ_STAT at 0x10 and irq_o.
module vga_axil_regs
  import vga_axil_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_ni,
  vga_axil_if.slave   bus,
  input  logic        frame_done_i,
  output logic        vga_en_o,
  output logic        test_pat_o,
  output logic [11:0] bg_color_o,
  output logic        irq_o
);

  localparam axil_data_t ID_VAL = 32'h5647_4101;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [11:0] bg_q, bg_d;
  axil_data_t  cnt_q, cnt_d;
  logic        aw_held_q, aw_held_d;
  logic [29:0] awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [11:0] wdata_q, wdata_d;
  logic [1:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  axil_data_t  rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        stat_q, stat_d;
  logic        irq_q, irq_d;

  logic        aw_hs, w_hs, commit;
  logic [29:0] wa;
  logic [11:0] wd;
  logic [1:0]  ws;
  logic [4:0]  wsel, rsel;

  assign bus.arready_o = !rvalid_q;
  assign bus.awready_o = !aw_held_q && !bvalid_q;
  assign bus.wready_o  = !w_held_q && !bvalid_q;
  assign bus.bvalid_o  = bvalid_q;
  assign bus.bresp_o   = bresp_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.rresp_o   = rresp_q;

  assign vga_en_o   = ctrl_q[0];
  assign test_pat_o = ctrl_q[1];
  assign bg_color_o = bg_q;
  assign irq_o      = irq_q;

  always_comb begin
    ctrl_d    = ctrl_q;
    bg_d      = bg_q;
    cnt_d     = cnt_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    stat_d    = 1'b0;
    irq_d     = 1'b0;

    aw_hs = bus.awvalid_i && bus.awready_o;
    w_hs  = bus.wvalid_i && bus.wready_o;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = bus.awaddr_i[31:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = bus.wdata_i[11:0];
      wstrb_d  = bus.wstrb_i[1:0];
    end

    // Held beats take priority; a live beat is used on its handshake edge.
    wa = aw_held_q ? awaddr_q : bus.awaddr_i[31:2];
    wd = w_held_q ? wdata_q : bus.wdata_i[11:0];
    ws = w_held_q ? wstrb_q : bus.wstrb_i[1:0];
    commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    for (int i = 0; i < 5; i++) begin
      wsel[i] = (wa[29:3] == '0) && (wa[2:0] == 3'(i));
      rsel[i] = (bus.araddr_i[31:5] == '0)
             && (bus.araddr_i[4:2] == 3'(i));
    end

    if (frame_done_i) cnt_d = cnt_q + 32'd1;

    if (bvalid_q && bus.bready_i) bvalid_d = 1'b0;

`ifdef VGA_AXIL_REGS_IRQ_EN
    stat_d = stat_q;
`endif

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      unique case (1'b1)
        wsel[0]: begin
          bresp_d = RESP_OKAY;
`ifdef VGA_AXIL_REGS_IRQ_EN
          if (ws[0]) ctrl_d = wd[2:0];
`else
          if (ws[0]) ctrl_d = {1'b0, wd[1:0]};
`endif
        end
        wsel[1]: begin
          bresp_d = RESP_OKAY;
          if (ws[0]) bg_d[7:0]  = wd[7:0];
          if (ws[1]) bg_d[11:8] = wd[11:8];
        end
`ifdef VGA_AXIL_REGS_IRQ_EN
        wsel[4]: begin
          bresp_d = RESP_OKAY;
          if (ws[0] && wd[0]) stat_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end

`ifdef VGA_AXIL_REGS_IRQ_EN
    // A frame event overrides a W1C clear landing on the same edge.
    if (frame_done_i) stat_d = 1'b1;
    irq_d = stat_d && ctrl_d[2];
`endif

    if (rvalid_q && bus.rready_i) rvalid_d = 1'b0;

    // Read sources are the pre-edge values of every register.
    if (bus.arvalid_i && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      unique case (1'b1)
        rsel[0]: rdata_d = {29'd0, ctrl_q};
        rsel[1]: rdata_d = {20'd0, bg_q};
        rsel[2]: rdata_d = cnt_q;
        rsel[3]: rdata_d = ID_VAL;
`ifdef VGA_AXIL_REGS_IRQ_EN
        rsel[4]: rdata_d = {31'd0, stat_q};
`endif
        default: rresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ctrl_q    <= '0;
      bg_q      <= '0;
      cnt_q     <= '0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      stat_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      bg_q      <= bg_d;
      cnt_q     <= cnt_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      stat_q    <= stat_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_vga_axil_regs.sv
// Directed plus randomized bench for vga_axil_regs against a register-map model.
// Build with or without VGA_AXIL_REGS_IRQ_EN to match the RTL.
module tb_vga_axil_regs;
  import vga_axil_pkg::*;

`ifdef VGA_AXIL_REGS_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_done = 1'b0;
  logic vga_en, test_pat, irq;
  logic [11:0] bg_color;

  always #5 clk = ~clk;

  vga_axil_if bus();

  vga_axil_regs dut (
    .clk_i(clk),
    .arst_ni(rst_n),
    .bus(bus),
    .frame_done_i(frame_done),
    .vga_en_o(vga_en),
    .test_pat_o(test_pat),
    .bg_color_o(bg_color),
    .irq_o(irq)
  );

  int checks = 0;
  int errors = 0;

  // Register-map model
  logic [2:0]  m_ctrl;
  logic [11:0] m_bg;
  logic [31:0] m_cnt;
  logic        m_stat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_bg = '0; m_cnt = '0; m_stat = 1'b0;
  endtask

  function automatic logic [33:0] m_read(input logic [31:0] a);
    int word;
    if (a >= 32) return {RESP_SLVERR, 32'd0};
    word = int'(a) / 4;
    case (word)
      0: return {RESP_OKAY, 29'd0, m_ctrl};
      1: return {RESP_OKAY, 20'd0, m_bg};
      2: return {RESP_OKAY, m_cnt};
      3: return {RESP_OKAY, 32'h5647_4101};
      4: if (HAS_IRQ) return {RESP_OKAY, 31'd0, m_stat};
      default: ;
    endcase
    return {RESP_SLVERR, 32'd0};
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] r);
    int word;
    logic [31:0] cur;
    r = RESP_SLVERR;
    if (a >= 32) return;
    word = int'(a) / 4;
    if (word == 0 || word == 1) begin
      cur = (word == 0) ? {29'd0, m_ctrl} : {20'd0, m_bg};
      for (int b = 0; b < 4; b++)
        if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
      if (word == 0) m_ctrl = cur[2:0] & (HAS_IRQ ? 3'd7 : 3'd3);
      else m_bg = cur[11:0];
      r = RESP_OKAY;
    end else if (word == 4 && HAS_IRQ) begin
      if (s[0] && d[0]) m_stat = 1'b0;
      r = RESP_OKAY;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".vga_en"}, vga_en, m_ctrl[0]);
    chk({tag, ".test_pat"}, test_pat, m_ctrl[1]);
    chk({tag, ".bg"}, bg_color, m_bg);
    chk({tag, ".irq"}, irq, HAS_IRQ ? (m_stat & m_ctrl[2]) : 1'b0);
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      m_cnt = m_cnt + 1;
      m_stat = 1'b1;
    end
  endtask

  // Starts and ends at a negedge. skew>0: AW leads W; skew<0: W leads AW.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int skew,
                           input int bdly);
    int aw_t, w_t, t;
    bit aw_done, w_done, aw_hit, w_hit;
    logic [1:0] exp_r;
    aw_t = (skew < 0) ? -skew : 0;
    w_t  = (skew > 0) ? skew : 0;
    aw_done = 0; w_done = 0; t = 0;
    bus.awaddr_i = a; bus.wdata_i = d; bus.wstrb_i = s;
    while (!(aw_done && w_done) && t < 50) begin
      bus.awvalid_i = !aw_done && (t >= aw_t);
      bus.wvalid_i  = !w_done && (t >= w_t);
      #1;
      aw_hit = bus.awvalid_i && bus.awready_o;
      w_hit  = bus.wvalid_i && bus.wready_o;
      @(negedge clk);
      aw_done |= aw_hit;
      w_done  |= w_hit;
      t++;
    end
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    m_write(a, d, s, exp_r);
    chk("wr_bvalid_lat", bus.bvalid_o, 1'b1);
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("wr_bvalid_hold", bus.bvalid_o, 1'b1);
      chk("wr_rdy_low", {bus.awready_o, bus.wready_o}, 2'b00);
    end
    chk("wr_bresp", bus.bresp_o, exp_r);
    bus.bready_i = 1'b1;
    @(negedge clk);
    bus.bready_i = 1'b0;
    chk("wr_bvalid_clr", bus.bvalid_o, 1'b0);
    chk("wr_rdy_back", {bus.awready_o, bus.wready_o}, 2'b11);
  endtask

  // fd pulses frame_done on the AR sample edge.
  task automatic axi_read(input logic [31:0] a, input bit fd,
                          input int rdly);
    logic [33:0] exp;
    int n;
    exp = m_read(a);
    bus.araddr_i  = a;
    bus.arvalid_i = 1'b1;
    frame_done    = fd;
    chk("rd_arready", bus.arready_o, 1'b1);
    @(negedge clk);
    bus.arvalid_i = 1'b0;
    frame_done    = 1'b0;
    if (fd) begin
      m_cnt = m_cnt + 1;
      m_stat = 1'b1;
    end
    n = 0;
    while (!bus.rvalid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rd_hold", bus.rvalid_o, 1'b1);
      chk("rd_arready_low", bus.arready_o, 1'b0);
    end
    chk("rd_data", bus.rdata_o, exp[31:0]);
    chk("rd_resp", bus.rresp_o, exp[33:32]);
    bus.rready_i = 1'b1;
    @(negedge clk);
    bus.rready_i = 1'b0;
    chk("rd_rvalid_clr", bus.rvalid_o, 1'b0);
  endtask

  logic [31:0] addr_tab [11];
  logic [31:0] ra, rd;
  int op;

  initial begin
    addr_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                 32'h18, 32'h1C, 32'h20, 32'h100, 32'h8000_0004};
    bus.araddr_i = '0; bus.arvalid_i = 0; bus.rready_i = 0;
    bus.awaddr_i = '0; bus.awvalid_i = 0; bus.wdata_i = '0;
    bus.wstrb_i = '0; bus.wvalid_i = 0; bus.bready_i = 0;
    m_reset();
    #12;
    chk("rst_rvalid", bus.rvalid_o, 1'b0);
    chk("rst_bvalid", bus.bvalid_o, 1'b0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_resp", {bus.rresp_o, bus.bresp_o}, 4'd0);
    chk("rst_readys", {bus.arready_o, bus.awready_o, bus.wready_o}, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("rst");

    // ID and CTRL reset value
    axi_read(32'h0C, 0, 0);
    axi_read(32'h00, 0, 1);

    // Byte-strobed BG_COLOR
    axi_write(32'h04, 32'h0000_0ABC, 4'b0001, 0, 0);
    axi_write(32'h04, 32'h0000_0F00, 4'b0010, 0, 0);
    axi_read(32'h04, 0, 0);
    chk("bg_fbc", bg_color, 12'hFBC);

    // AW leads W by 2, bready delayed 3 cycles
    axi_write(32'h04, 32'h0000_0123, 4'b0011, 2, 3);
    axi_write(32'h00, 32'h0000_0003, 4'b0001, -2, 1);
    axi_read(32'h04, 0, 0);
    check_outs("skew");

    // Errors
    axi_write(32'h08, 32'h1234_5678, 4'b1111, 0, 0);
    axi_write(32'h0C, 32'h0, 4'b1111, 1, 0);
    axi_read(32'h20, 0, 0);
    axi_read(32'h08, 0, 0);

    // Frame counter, pre-increment read, wrap
    pulse_frames(5);
    axi_read(32'h08, 0, 0);
    axi_read(32'h08, 1, 0);
    axi_read(32'h08, 0, 0);
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    axi_read(32'h08, 0, 0);
    pulse_frames(1);
    axi_read(32'h08, 0, 0);

    // Interrupt
    axi_write(32'h10, 32'h1, 4'b0001, 0, 0);
    axi_write(32'h00, 32'h4, 4'b0001, 0, 0);
    check_outs("irq_idle");
    pulse_frames(1);
    chk("irq_set", irq, HAS_IRQ);
    axi_read(32'h10, 0, 0);
    axi_write(32'h10, 32'h1, 4'b0001, 0, 0);
    chk("irq_clr", irq, 1'b0);
    check_outs("irq");

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      ra = addr_tab[$urandom_range(10, 0)] | 32'($urandom_range(3, 0));
      op = $urandom_range(2, 0);
      if (op == 0) begin
        rd = $urandom;
        axi_write(ra, rd, 4'($urandom_range(15, 0)),
                  $urandom_range(4, 0) - 2, $urandom_range(2, 0));
      end else if (op == 1) begin
        axi_read(ra, 1'($urandom_range(1, 0)), $urandom_range(2, 0));
      end else begin
        pulse_frames($urandom_range(3, 0));
      end
      check_outs("rand");
    end

    // Reset in the middle of a write
    axi_write(32'h04, 32'h0000_0555, 4'b0011, 0, 0);
    bus.awaddr_i = 32'h04; bus.awvalid_i = 1'b1;
    @(negedge clk);
    bus.awvalid_i = 1'b0;
    chk("mid_aw_held", bus.awready_o, 1'b0);
    rst_n = 1'b0;
    #2;
    m_reset();
    chk("mid_rst_readys", {bus.arready_o, bus.awready_o, bus.wready_o}, 3'b111);
    check_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_write(32'h00, 32'h0000_0002, 4'b0001, 0, 0);
    axi_read(32'h04, 0, 0);
    axi_read(32'h08, 0, 0);
    check_outs("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
